// File: rtl/dwc_pkg.sv
// Shared definitions for the data-width-converter write-response path:
// BRESP encodings, merge FSM states and the worst-case response merge.
package dwc_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COLLECT = 2'd1,
      ST_HOLD    = 2'd2
   } merge_state_e;

   // EXOKAY ranks below OKAY so it only survives when every beat was EXOKAY.
   function automatic logic [1:0] resp_rank(input logic [1:0] resp);
      logic [1:0] rank;
      case (resp)
         RESP_EXOKAY: rank = 2'd0;
         RESP_OKAY:   rank = 2'd1;
         RESP_SLVERR: rank = 2'd2;
         default:     rank = 2'd3;
      endcase
      return rank;
   endfunction

   function automatic logic [1:0] resp_merge(input logic [1:0] a, input logic [1:0] b);
      return (resp_rank(b) > resp_rank(a)) ? b : a;
   endfunction

endpackage

// File: rtl/dwc_sync_fifo.sv
// Registered synchronous FIFO, head readable the cycle after the push.
// Full accepts a write only alongside a read; reads of an empty FIFO are ignored.
module dwc_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             wr_en,
   input  logic [WIDTH-1:0]                 wr_dat,
   input  logic                             rd_en,
   output logic [WIDTH-1:0]                 rd_dat,
   output logic                             full,
   output logic                             empty,
   output logic [$clog2(DEPTH+1)-1:0]       level
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = $clog2(DEPTH+1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_wr;
   logic             do_rd;

   assign full   = (level == LVL_W'(DEPTH));
   assign empty  = (level == '0);
   assign do_rd  = rd_en & ~empty;
   assign do_wr  = wr_en & (~full | do_rd);
   assign rd_dat = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_wr) mem[wr_ptr] <= wr_dat;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_wr) wr_ptr <= (wr_ptr == PTR_W'(DEPTH-1)) ? '0 : wr_ptr + PTR_W'(1);
         if (do_rd) rd_ptr <= (rd_ptr == PTR_W'(DEPTH-1)) ? '0 : rd_ptr + PTR_W'(1);
         case ({do_wr, do_rd})
            2'b10:   level <= level + LVL_W'(1);
            2'b01:   level <= level - LVL_W'(1);
            default: level <= level;
         endcase
      end
   end

endmodule

// File: rtl/dwc_bresp_merge.sv
// Merges cnt+1 slave B responses per command into one master B (worst BRESP, last BUSER), 1 cycle after the last beat.
// Slave B stalls while the FIFO is empty or a master B is pending with MASTER_BREADY low.
module dwc_bresp_merge
   import dwc_pkg::*;
#(
   parameter int ID_WIDTH       = 1,
   parameter int USER_WIDTH     = 1,
   parameter int CNT_WIDTH      = 4,
   parameter int CMD_FIFO_DEPTH = 4
) (
   input  logic                  ACLK,
   input  logic                  sysReset,
   input  logic                  cmd_wr_en,
   input  logic [ID_WIDTH-1:0]   cmd_wr_id,
   input  logic [CNT_WIDTH-1:0]  cmd_wr_cnt,
   output logic                  cmd_fifo_full,
   input  logic [ID_WIDTH-1:0]   SLAVE_BID,
   input  logic [1:0]            SLAVE_BRESP,
   input  logic [USER_WIDTH-1:0] SLAVE_BUSER,
   input  logic                  SLAVE_BVALID,
   output logic                  SLAVE_BREADY,
   output logic [ID_WIDTH-1:0]   MASTER_BID,
   output logic [1:0]            MASTER_BRESP,
   output logic [USER_WIDTH-1:0] MASTER_BUSER,
   output logic                  MASTER_BVALID,
   input  logic                  MASTER_BREADY,
   output logic                  id_mismatch_err,
   output logic                  cmd_overflow_err
);

   localparam int CMD_W = ID_WIDTH + CNT_WIDTH;
   localparam int LVL_W = $clog2(CMD_FIFO_DEPTH+1);

   merge_state_e          state, state_nxt;
   logic [CMD_W-1:0]      head_dat;
   logic [ID_WIDTH-1:0]   head_id;
   logic [CNT_WIDTH-1:0]  head_cnt;
   logic                  fifo_empty;
   logic [LVL_W-1:0]      fifo_level;
   logic [LVL_W-1:0]      level_nxt;
   logic [CNT_WIDTH-1:0]  sub_cnt;
   logic [1:0]            acc_resp;
   logic [USER_WIDTH-1:0] acc_user;
   logic [1:0]            merged_resp;
   logic                  slave_hs;
   logic                  last_beat;
   logic                  push_acc;
   logic                  bvalid_nxt;

   dwc_sync_fifo #(
      .WIDTH (CMD_W),
      .DEPTH (CMD_FIFO_DEPTH)
   ) u_cmd_fifo (
      .clk    (ACLK),
      .rst_n  (sysReset),
      .wr_en  (cmd_wr_en),
      .wr_dat ({cmd_wr_id, cmd_wr_cnt}),
      .rd_en  (last_beat),
      .rd_dat (head_dat),
      .full   (cmd_fifo_full),
      .empty  (fifo_empty),
      .level  (fifo_level)
   );

   assign head_id  = head_dat[CMD_W-1:CNT_WIDTH];
   assign head_cnt = head_dat[CNT_WIDTH-1:0];

   assign MASTER_BVALID    = (state == ST_HOLD);
   assign SLAVE_BREADY     = ~fifo_empty & (~MASTER_BVALID | MASTER_BREADY);
   assign slave_hs         = SLAVE_BVALID & SLAVE_BREADY;
   assign last_beat        = slave_hs & (sub_cnt == head_cnt);
   assign push_acc         = cmd_wr_en & (~cmd_fifo_full | last_beat);
   assign cmd_overflow_err = cmd_wr_en & cmd_fifo_full & ~last_beat;
   assign id_mismatch_err  = slave_hs & (SLAVE_BID != head_id);

   // First beat of a command seeds the merge so nothing leaks across commands.
   assign merged_resp = (sub_cnt == '0) ? SLAVE_BRESP : resp_merge(acc_resp, SLAVE_BRESP);

   always_comb begin
      bvalid_nxt = last_beat | (MASTER_BVALID & ~MASTER_BREADY);
      level_nxt  = fifo_level + LVL_W'(push_acc) - LVL_W'(last_beat);
      state_nxt  = state;
      if (bvalid_nxt)
         state_nxt = ST_HOLD;
      else if (level_nxt != '0)
         state_nxt = ST_COLLECT;
      else
         state_nxt = ST_IDLE;
   end

   always_ff @(posedge ACLK or negedge sysReset) begin
      if (!sysReset)
         state <= ST_IDLE;
      else
         state <= state_nxt;
   end

   always_ff @(posedge ACLK or negedge sysReset) begin
      if (!sysReset) begin
         sub_cnt      <= '0;
         acc_resp     <= '0;
         acc_user     <= '0;
         MASTER_BID   <= '0;
         MASTER_BRESP <= '0;
         MASTER_BUSER <= '0;
      end else if (slave_hs) begin
         if (last_beat) begin
            MASTER_BID   <= head_id;
            MASTER_BRESP <= merged_resp;
            MASTER_BUSER <= SLAVE_BUSER;
            sub_cnt      <= '0;
            acc_resp     <= '0;
            acc_user     <= '0;
         end else begin
            sub_cnt  <= sub_cnt + CNT_WIDTH'(1);
            acc_resp <= merged_resp;
            acc_user <= SLAVE_BUSER;
         end
      end
   end

endmodule

// File: tb/tb_dwc_bresp_merge.sv
// Scoreboard bench for dwc_bresp_merge: expected master B responses are queued as
// slave beats are driven and compared when the master handshake completes.
module tb_dwc_bresp_merge;

   localparam int IDW = 3;
   localparam int UW  = 2;
   localparam int CW  = 4;

   logic           ACLK = 1'b0;
   logic           sysReset = 1'b0;
   logic           cmd_wr_en = 1'b0;
   logic [IDW-1:0] cmd_wr_id = '0;
   logic [CW-1:0]  cmd_wr_cnt = '0;
   logic           cmd_fifo_full;
   logic [IDW-1:0] SLAVE_BID = '0;
   logic [1:0]     SLAVE_BRESP = '0;
   logic [UW-1:0]  SLAVE_BUSER = '0;
   logic           SLAVE_BVALID = 1'b0;
   logic           SLAVE_BREADY;
   logic [IDW-1:0] MASTER_BID;
   logic [1:0]     MASTER_BRESP;
   logic [UW-1:0]  MASTER_BUSER;
   logic           MASTER_BVALID;
   logic           MASTER_BREADY = 1'b1;
   logic           id_mismatch_err;
   logic           cmd_overflow_err;

   typedef struct {
      logic [IDW-1:0] id;
      logic [1:0]     resp;
      logic [UW-1:0]  user;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   vectors = 0;
   int   miscompares = 0;
   int   mism_cnt = 0;
   bit   hold_prev = 0;
   logic [7:0] prev_pay = '0;

   dwc_bresp_merge #(
      .ID_WIDTH(IDW), .USER_WIDTH(UW), .CNT_WIDTH(CW), .CMD_FIFO_DEPTH(4)
   ) dut (
      .ACLK(ACLK), .sysReset(sysReset),
      .cmd_wr_en(cmd_wr_en), .cmd_wr_id(cmd_wr_id), .cmd_wr_cnt(cmd_wr_cnt),
      .cmd_fifo_full(cmd_fifo_full),
      .SLAVE_BID(SLAVE_BID), .SLAVE_BRESP(SLAVE_BRESP), .SLAVE_BUSER(SLAVE_BUSER),
      .SLAVE_BVALID(SLAVE_BVALID), .SLAVE_BREADY(SLAVE_BREADY),
      .MASTER_BID(MASTER_BID), .MASTER_BRESP(MASTER_BRESP), .MASTER_BUSER(MASTER_BUSER),
      .MASTER_BVALID(MASTER_BVALID), .MASTER_BREADY(MASTER_BREADY),
      .id_mismatch_err(id_mismatch_err), .cmd_overflow_err(cmd_overflow_err)
   );

   always #5 ACLK = ~ACLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge ACLK);
      #1;
   endtask

   // Independent worst-case reduction over the whole beat list.
   function automatic logic [1:0] worst_resp(input logic [1:0] r[16], input int n);
      bit dec = 0, slv = 0, ok = 0;
      for (int i = 0; i < n; i++) begin
         if (r[i] == 2'b11) dec = 1;
         if (r[i] == 2'b10) slv = 1;
         if (r[i] == 2'b00) ok = 1;
      end
      if (dec) return 2'b11;
      if (slv) return 2'b10;
      if (ok)  return 2'b00;
      return 2'b01;
   endfunction

   task automatic push_cmd(input logic [IDW-1:0] id, input logic [CW-1:0] cnt);
      cmd_wr_en  = 1'b1;
      cmd_wr_id  = id;
      cmd_wr_cnt = cnt;
      step();
      cmd_wr_en  = 1'b0;
   endtask

   task automatic slave_beat(input logic [IDW-1:0] id, input logic [1:0] resp, input logic [UW-1:0] user);
      bit hs = 0;
      SLAVE_BVALID = 1'b1;
      SLAVE_BID    = id;
      SLAVE_BRESP  = resp;
      SLAVE_BUSER  = user;
      for (int i = 0; i < 64 && !hs; i++) begin
         @(negedge ACLK);
         hs = SLAVE_BREADY;
         step();
      end
      SLAVE_BVALID = 1'b0;
      if (!hs) chk("slave_hs_timeout", 0, 1);
   endtask

   task automatic run_cmd(input logic [IDW-1:0] id, input logic [CW-1:0] cnt,
                          input logic [1:0] r[16], input logic [UW-1:0] u[16]);
      exp_t e;
      push_cmd(id, cnt);
      e.id   = id;
      e.resp = worst_resp(r, int'(cnt) + 1);
      e.user = u[cnt];
      exp_q.push_back(e);
      for (int i = 0; i <= int'(cnt); i++) slave_beat(id, r[i], u[i]);
   endtask

   task automatic expect_b(input logic [IDW-1:0] id, input logic [1:0] resp, input logic [UW-1:0] user);
      exp_t e;
      e.id = id; e.resp = resp; e.user = user;
      exp_q.push_back(e);
   endtask

   always @(negedge ACLK) begin
      if (sysReset) begin
         if (hold_prev)
            chk("hold_stable", {MASTER_BVALID, MASTER_BID, MASTER_BRESP, MASTER_BUSER}, prev_pay);
         if (MASTER_BVALID && MASTER_BREADY) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_b", 1, 0);
            end else begin
               mon_e = exp_q.pop_front();
               chk("bid",   MASTER_BID,   mon_e.id);
               chk("bresp", MASTER_BRESP, mon_e.resp);
               chk("buser", MASTER_BUSER, mon_e.user);
            end
         end
         if (id_mismatch_err) mism_cnt++;
         hold_prev = MASTER_BVALID && !MASTER_BREADY;
         prev_pay  = {MASTER_BVALID, MASTER_BID, MASTER_BRESP, MASTER_BUSER};
      end else begin
         hold_prev = 0;
      end
   end

   logic [1:0]    ra [16];
   logic [UW-1:0] ua [16];
   int            base;

   initial begin
      // Reset state
      repeat (2) @(negedge ACLK);
      chk("rst_bvalid", MASTER_BVALID, 0);
      chk("rst_bid",    MASTER_BID, 0);
      chk("rst_bresp",  MASTER_BRESP, 0);
      chk("rst_buser",  MASTER_BUSER, 0);
      chk("rst_sready", SLAVE_BREADY, 0);
      chk("rst_full",   cmd_fifo_full, 0);
      chk("rst_errs",   {id_mismatch_err, cmd_overflow_err}, 0);
      step();
      sysReset = 1'b1;
      step();

      // Single pass-through, one-cycle latency
      ra[0] = 2'b00; ua[0] = 2'd2;
      run_cmd(3, 0, ra, ua);
      @(negedge ACLK);
      chk("lat1_bvalid", MASTER_BVALID, 1);
      step();

      // Four-way split, worst case DECERR, last user wins
      ra[0] = 2'b00; ra[1] = 2'b10; ra[2] = 2'b00; ra[3] = 2'b11;
      ua[0] = 2'd1;  ua[1] = 2'd2;  ua[2] = 2'd3;  ua[3] = 2'd2;
      run_cmd(5, 3, ra, ua);

      // EXOKAY only survives when unanimous
      ra[0] = 2'b01; ra[1] = 2'b01; ua[0] = 2'd0; ua[1] = 2'd1;
      run_cmd(1, 1, ra, ua);
      ra[0] = 2'b01; ra[1] = 2'b00; ua[0] = 2'd3; ua[1] = 2'd0;
      run_cmd(1, 1, ra, ua);
      ra[0] = 2'b01; ua[0] = 2'd3;
      run_cmd(4, 0, ra, ua);

      // Maximum split count, no counter wrap
      for (int i = 0; i < 16; i++) begin
         ra[i] = 2'b01;
         ua[i] = UW'(i);
      end
      run_cmd(6, 15, ra, ua);
      repeat (2) step();

      // Fill, overflow drop, push plus pop at full
      for (int i = 0; i < 4; i++) push_cmd(IDW'(i), 0);
      @(negedge ACLK);
      chk("full_after_4", cmd_fifo_full, 1);
      step();
      cmd_wr_en = 1'b1; cmd_wr_id = 6; cmd_wr_cnt = 0;
      @(negedge ACLK);
      chk("ovf_pulse", cmd_overflow_err, 1);
      step();
      cmd_wr_id = 4;
      SLAVE_BVALID = 1'b1; SLAVE_BID = 0; SLAVE_BRESP = 2'b00; SLAVE_BUSER = 2'd0;
      expect_b(0, 2'b00, 2'd0);
      @(negedge ACLK);
      chk("ovf_at_pop", cmd_overflow_err, 0);
      chk("sready_full", SLAVE_BREADY, 1);
      step();
      cmd_wr_en = 1'b0; SLAVE_BVALID = 1'b0;
      @(negedge ACLK);
      chk("full_after_swap", cmd_fifo_full, 1);
      step();
      expect_b(1, 2'b00, 2'd1); slave_beat(1, 2'b00, 2'd1);
      expect_b(2, 2'b10, 2'd2); slave_beat(2, 2'b10, 2'd2);
      expect_b(3, 2'b00, 2'd3); slave_beat(3, 2'b00, 2'd3);
      expect_b(4, 2'b01, 2'd0); slave_beat(4, 2'b01, 2'd0);
      repeat (2) step();
      chk("empty_after_drain", SLAVE_BREADY, 0);

      // Master backpressure stalls the slave side
      MASTER_BREADY = 1'b0;
      push_cmd(2, 0);
      push_cmd(4, 0);
      expect_b(2, 2'b00, 2'd1);
      slave_beat(2, 2'b00, 2'd1);
      SLAVE_BVALID = 1'b1; SLAVE_BID = 4; SLAVE_BRESP = 2'b10; SLAVE_BUSER = 2'd3;
      expect_b(4, 2'b10, 2'd3);
      for (int i = 0; i < 3; i++) begin
         @(negedge ACLK);
         chk("stall_sready", SLAVE_BREADY, 0);
         chk("stall_bid", MASTER_BID, 2);
      end
      step();
      MASTER_BREADY = 1'b1;
      @(negedge ACLK);
      chk("release_sready", SLAVE_BREADY, 1);
      step();
      SLAVE_BVALID = 1'b0;
      @(negedge ACLK);
      chk("b2b_bvalid", MASTER_BVALID, 1);
      chk("b2b_bid", MASTER_BID, 4);
      step();

      // ID mismatch still merges, master ID from the command
      base = mism_cnt;
      push_cmd(2, 1);
      expect_b(2, 2'b10, 2'd2);
      slave_beat(7, 2'b00, 2'd1);
      slave_beat(2, 2'b10, 2'd2);
      @(negedge ACLK);
      chk("mismatch_pulses", mism_cnt - base, 1);
      step();

      // Reset mid-command discards partial state
      push_cmd(5, 2);
      slave_beat(5, 2'b11, 2'd1);
      sysReset = 1'b0;
      @(negedge ACLK);
      chk("mrst_outs", {MASTER_BVALID, MASTER_BID, MASTER_BRESP, MASTER_BUSER}, 0);
      chk("mrst_flags", {SLAVE_BREADY, cmd_fifo_full, id_mismatch_err, cmd_overflow_err}, 0);
      step();
      sysReset = 1'b1;
      SLAVE_BVALID = 1'b1; SLAVE_BID = 5; SLAVE_BRESP = 2'b00; SLAVE_BUSER = 2'd0;
      for (int i = 0; i < 3; i++) begin
         @(negedge ACLK);
         chk("post_rst_sready", SLAVE_BREADY, 0);
      end
      step();
      SLAVE_BVALID = 1'b0;
      ra[0] = 2'b11; ua[0] = 2'd1;
      run_cmd(6, 0, ra, ua);

      for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
      chk("sb_empty", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/dwc_bresp_merge.md
# dwc_bresp_merge

Write-response merger for the data-width converters. When the AW path splits one master write into several slave writes, it pushes one command per master write: the master ID plus the number of slave sub-transactions. This block consumes that many slave B responses, merges them into one master B response with worst-case BRESP, and returns it with the original ID. It generalises the single-response B-channel handler to N-way splits, with programmable command depth and ID-mismatch detection.

## Interface
- ID_WIDTH, 1, AXI ID width.
- USER_WIDTH, 1, BUSER width.
- CNT_WIDTH, 4, width of the sub-transaction count field (up to 2^CNT_WIDTH splits).
- CMD_FIFO_DEPTH, 4, command FIFO entries; must be ≥2.
- ACLK  in  1  clock, all logic on the rising edge.
- sysReset  in  1  asynchronous, active-low reset.
- cmd_wr_en  in  1  push command.
- cmd_wr_id  in  ID_WIDTH  master AWID.
- cmd_wr_cnt  in  CNT_WIDTH  number of sub-transactions minus 1.
- cmd_fifo_full  out  1  no free entry.
- SLAVE_BID  in  ID_WIDTH  slave response ID.
- SLAVE_BRESP  in  2  slave response.
- SLAVE_BUSER  in  USER_WIDTH  slave user bits.
- SLAVE_BVALID  in  1  slave handshake.
- SLAVE_BREADY  out  1  slave handshake.
- MASTER_BID  out  ID_WIDTH  merged response ID.
- MASTER_BRESP  out  2  merged response.
- MASTER_BUSER  out  USER_WIDTH  merged user bits.
- MASTER_BVALID  out  1  master handshake.
- MASTER_BREADY  in  1  master handshake.
- id_mismatch_err  out  1  one-cycle pulse: accepted SLAVE_BID differs from the head command ID.
- cmd_overflow_err  out  1  one-cycle pulse: cmd_wr_en while full and not popping.

## Operation
- Command FIFO holds {id, cnt}. Push on cmd_wr_en when not full, or when full with a same-cycle pop. Otherwise the push is dropped and cmd_overflow_err pulses.
- Sub-beat counter `sub_cnt` (CNT_WIDTH) and accumulator `acc_resp` and `acc_user` track the head command.
- SLAVE_BREADY = FIFO not empty AND (MASTER_BVALID low OR MASTER_BREADY high).
- On each slave handshake:
  - Merge: acc_resp ← max-severity(acc_resp, SLAVE_BRESP). Severity order: DECERR(11) > SLVERR(10) > OKAY(00) > EXOKAY(01).
  - EXOKAY survives only if every sub-response was EXOKAY. Any mix of OKAY and EXOKAY gives OKAY.
  - acc_user ← SLAVE_BUSER (last beat wins).
- If sub_cnt == head.cnt (last sub-response):
  - Load the output registers: MASTER_BID ← head.id, plus the merged resp and user.
  - Set MASTER_BVALID, pop the FIFO, clear sub_cnt and the accumulator.
- Otherwise sub_cnt increments.
- The first beat of each command initialises the accumulator from the incoming response; nothing carries over from the previous command.
- If SLAVE_BID != head.id, id_mismatch_err pulses. The response is still merged; the master ID always comes from the FIFO.
- MASTER_BVALID clears on a master handshake unless a new last beat loads the register in the same cycle.
- States: IDLE (FIFO empty), COLLECT (head valid, output free or draining), HOLD (output valid, MASTER_BREADY low, slave stalled).

## Timing
- Reset values: every output is 0, the FIFO is empty, and the counters and accumulator are 0. cmd_fifo_full deasserts in reset.
- Latency is 1 cycle from the last slave handshake to MASTER_BVALID.
- Throughput is one slave B per cycle, and back-to-back master B per cycle when MASTER_BREADY is held high.
- The head is visible to the merge logic the cycle after the push (registered FIFO). There is no same-cycle push-to-accept bypass.
- cnt = 0 passes a single response through, EXOKAY preserved.
- cnt = 2^CNT_WIDTH−1: sub_cnt reaches the all-ones value with no wrap before the pop.
- Simultaneous push and pop at full: the push is accepted and full stays asserted.
- Once asserted, MASTER_BVALID and its payload are stable until the handshake.
- Reset mid-command discards all partial state; no response is emitted afterwards for that command.

## Structure
- Shared package `dwc_pkg`:
  - BRESP encodings (RESP_OKAY, RESP_EXOKAY, RESP_SLVERR, RESP_DECERR).
  - The severity-merge function.
- One sub-module `dwc_sync_fifo` (parametrised width/depth, full/empty flags, async active-low reset) for the command store.
- The merge counter and output register live in the top.

## Test plan
- Push {id=3, cnt=0}; slave B OKAY id=3 → MASTER_BVALID the next cycle with BID=3, BRESP=00.
- Push {id=5, cnt=3}; slave resps OKAY, SLVERR, OKAY, DECERR → one master B, BID=5, BRESP=11, BUSER = last beat's user.
- Push {id=1, cnt=1}; resps EXOKAY, EXOKAY → BRESP=01. Repeat with EXOKAY, OKAY → BRESP=00.
- Fill the FIFO (4 cmds, cnt=0) → cmd_fifo_full=1. Extra push → cmd_overflow_err pulse, entry dropped. Push plus pop at full → accepted.
- MASTER_BREADY held low after a response → SLAVE_BREADY=0 and the payload stays stable. Release → one handshake, then collection resumes.
- Slave BID=7 against head id=2 → id_mismatch_err pulse, MASTER_BID=2. Assert sysReset low mid-command → all outputs 0, no stale response after release.
